aes_key_sched: RTL and testbench

AES_KEY_SCHED -- requirements
Module: aes_key_sched

---
 rtl/aes_key_sched.sv | 120 ++++++++++++
 tb/tb_aes_key_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion for AES-128/192/256: one schedule word per clock,
// with the whole schedule held in registers for zero-latency round-key reads.
module aes_key_sched #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*NK-1:0] key,
  output logic            busy,
  output logic            done,
  output logic            rd_valid,
  input  logic [3:0]      rd_round,
  output logic [127:0]    rd_key
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state_q;
  logic [5:0]  i_q;
  logic [2:0]  j_q;      // i mod NK, tracked incrementally to avoid a divider
  logic [7:0]  rcon_q;
  logic        busy_q, done_q, valid_q;
  logic [31:0] w_q [NW];
  logic [31:0] prev, temp_d, word_d;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    prev   = w_q[i_q - 6'd1];
    temp_d = prev;
    if (j_q == 3'd0)
      temp_d = subword({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0};
    else if (NK == 8 && j_q == 3'd4)
      temp_d = subword(prev);
    word_d = w_q[i_q - 6'(NK)] ^ temp_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= EXPAND;
          i_q     <= 6'(NK);
          j_q     <= '0;
          rcon_q  <= 8'h01;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
        end
        EXPAND: begin
          i_q <= i_q + 6'd1;
          j_q <= (j_q == 3'(NK-1)) ? 3'd0 : j_q + 3'd1;
          if (j_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (i_q == 6'(NW-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Schedule storage is deliberately not reset; rd_key masks it while invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q != EXPAND && start) begin
        for (int k = 0; k < NK; k++) w_q[k] <= key[32*NK-1-32*k -: 32];
      end else if (state_q == EXPAND) begin
        w_q[i_q] <= word_d;
      end
    end
  end

  logic [5:0] base;
  always_comb begin
    base   = {rd_round, 2'b00};
    rd_key = '0;
    if (valid_q && rd_round <= 4'(NR))
      rd_key = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = valid_q;
endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched at NK=4/6/8 against FIPS-197 expansion vectors.
module tb_aes_key_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start_s [3];
  logic [3:0]   rr_s    [3];
  logic         busy_s  [3];
  logic         done_s  [3];
  logic         valid_s [3];
  logic [127:0] rk_s    [3];
  logic [127:0] k4;
  logic [191:0] k6;
  logic [255:0] k8;

  aes_key_sched #(.NK(4)) u4 (.clk(clk), .reset(reset), .start(start_s[0]), .key(k4),
    .busy(busy_s[0]), .done(done_s[0]), .rd_valid(valid_s[0]), .rd_round(rr_s[0]), .rd_key(rk_s[0]));
  aes_key_sched #(.NK(6)) u6 (.clk(clk), .reset(reset), .start(start_s[1]), .key(k6),
    .busy(busy_s[1]), .done(done_s[1]), .rd_valid(valid_s[1]), .rd_round(rr_s[1]), .rd_key(rk_s[1]));
  aes_key_sched #(.NK(8)) u8 (.clk(clk), .reset(reset), .start(start_s[2]), .key(k8),
    .busy(busy_s[2]), .done(done_s[2]), .rd_valid(valid_s[2]), .rd_round(rr_s[2]), .rd_key(rk_s[2]));

  localparam logic [127:0] K4 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  int passed = 0, total = 0, fails = 0;

  typedef struct {
    int           d;
    logic [3:0]   r;
    logic [127:0] e;
    string        tag;
  } exp_t;
  exp_t sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int r, input logic [127:0] e, input string tag);
    exp_t x;
    x.d = d; x.r = 4'(r); x.e = e; x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      rr_s[x.d] = x.r;
      #1;
      chk(x.tag, rk_s[x.d], x.e);
    end
  endtask

  // Pulses start for one cycle, then scrambles the key so late key changes are exercised.
  task automatic start_dut(input int d, input logic [255:0] k);
    @(negedge clk);
    case (d)
      0: k4 = k[127:0];
      1: k6 = k[191:0];
      default: k8 = k;
    endcase
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    k4 = ~k4; k6 = ~k6; k8 = ~k8;
  endtask

  task automatic wait_done(input int d, input int repulse, output int bc, output bit seen);
    bc = 0; seen = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done_s[d]) begin seen = 1'b1; break; end
      if (busy_s[d]) bc++;
      start_s[d] = (n == repulse);
      @(negedge clk);
    end
    start_s[d] = 1'b0;
  endtask

  initial begin
    int  bc, dcnt;
    bit  seen;
    reset = 1'b1;
    k4 = '0; k6 = '0; k8 = '0;
    for (int d = 0; d < 3; d++) begin start_s[d] = 1'b0; rr_s[d] = 4'd0; end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", 128'(busy_s[d]), 0);
      chk("rst_done", 128'(done_s[d]), 0);
      chk("rst_valid", 128'(valid_s[d]), 0);
      chk("rst_rdkey", rk_s[d], 0);
    end
    reset = 1'b0;

    // AES-128 baseline
    push(0, 0, K4, "n4_r0");
    push(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "n4_r1");
    push(0, 2, 128'hf2c295f27a96b9435935807a7359f67f, "n4_r2");
    push(0, 9, 128'hac7766f319fadc2128d12941575c006e, "n4_r9");
    push(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "n4_r10");
    start_dut(0, 256'(K4));
    chk("n4_busy_early", 128'(busy_s[0]), 1);
    wait_done(0, 0, bc, seen);
    chk("n4_done_seen", 128'(seen), 1);
    chk("n4_busy_cycles", 128'(bc), 40);
    chk("n4_valid", 128'(valid_s[0]), 1);
    chk("n4_busy_at_done", 128'(busy_s[0]), 0);
    @(negedge clk);
    chk("n4_done_width", 128'(done_s[0]), 0);
    drain();

    // out-of-range reads, then restart clears rd_valid
    rr_s[0] = 4'd11; #1;
    chk("n4_r11_zero", rk_s[0], 0);
    chk("n4_r11_valid", 128'(valid_s[0]), 1);
    rr_s[0] = 4'd15; #1;
    chk("n4_r15_zero", rk_s[0], 0);
    start_dut(0, 256'(K4));
    chk("restart_valid_clr", 128'(valid_s[0]), 0);
    chk("restart_busy", 128'(busy_s[0]), 1);

    // reset at cycle 20 of the expansion
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rr_s[0] = 4'd1; #1;
    chk("midrst_busy", 128'(busy_s[0]), 0);
    chk("midrst_valid", 128'(valid_s[0]), 0);
    chk("midrst_rdkey", rk_s[0], 0);
    dcnt = 0;
    repeat (50) begin @(negedge clk); if (done_s[0]) dcnt++; end
    chk("midrst_no_done", 128'(dcnt), 0);

    push(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "after_rst_r1");
    push(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "after_rst_r10");
    start_dut(0, 256'(K4));
    wait_done(0, 0, bc, seen);
    chk("after_rst_seen", 128'(seen), 1);
    chk("after_rst_cycles", 128'(bc), 40);
    drain();

    // start re-pulsed mid-expansion with a different key must be ignored
    push(0, 0, K4, "repulse_r0");
    push(0, 1, 128'ha0fafe1788542cb123a339392a6c7605, "repulse_r1");
    push(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "repulse_r10");
    start_dut(0, 256'(K4));
    wait_done(0, 10, bc, seen);
    chk("repulse_seen", 128'(seen), 1);
    chk("repulse_cycles", 128'(bc), 40);
    drain();

    // AES-192
    push(1, 0, K6[191:64], "n6_r0");
    push(1, 12, 128'he98ba06f448c773c8ecc720401002202, "n6_r12");
    push(1, 13, 128'h0, "n6_r13_zero");
    start_dut(1, 256'(K6));
    wait_done(1, 0, bc, seen);
    chk("n6_seen", 128'(seen), 1);
    chk("n6_cycles", 128'(bc), 46);
    drain();

    // AES-256
    push(2, 0, K8[255:128], "n8_r0");
    push(2, 1, K8[127:0], "n8_r1");
    push(2, 14, 128'hfe4890d1e6188d0b046df344706c631e, "n8_r14");
    push(2, 15, 128'h0, "n8_r15_zero");
    start_dut(2, K8);
    wait_done(2, 0, bc, seen);
    chk("n8_seen", 128'(seen), 1);
    chk("n8_cycles", 128'(bc), 52);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
